// File: rtl/sbit_oneshot_conditioner_pkg.sv
// Shared widths and helpers for the S-bit one-shot conditioner.
// Saturating increment is used by the slow-control monitoring counters.
package sbit_oneshot_conditioner_pkg;

    localparam int unsigned MXSBITS       = 64;
    localparam int unsigned DEADTIME_BITS = 4;
    localparam int unsigned HIT_CNT_BITS  = 16;
    localparam int unsigned LOST_CNT_BITS = 8;

    // Saturating +1 for a counter of width w (1..31) held in the low bits of v.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_val;
        max_val = (32'd1 << w) - 32'd1;
        if (v >= max_val) begin
            return max_val;
        end
        return v + 32'd1;
    endfunction

endpackage

// File: rtl/sbit_oneshot_conditioner_if.sv
// Bus between the frame aligner side and the conditioner: raw S-bits and
// controls in, conditioned S-bits and monitoring out.
interface sbit_oneshot_conditioner_if;
    import sbit_oneshot_conditioner_pkg::*;

    logic [MXSBITS-1:0]       sbits_i;
    logic                     aligned_i;
    logic                     unstable_i;
    logic [MXSBITS-1:0]       mask_i;
    logic [DEADTIME_BITS-1:0] deadtime_i;
    logic                     cnt_reset_i;

    logic [MXSBITS-1:0]       sbits_o;
    logic                     active_o;
    logic [HIT_CNT_BITS-1:0]  hit_cnt_o;
    logic [LOST_CNT_BITS-1:0] lost_cnt_o;
    logic                     unstable_o;

    modport master (
        output sbits_i, aligned_i, unstable_i, mask_i, deadtime_i, cnt_reset_i,
        input  sbits_o, active_o, hit_cnt_o, lost_cnt_o, unstable_o
    );

    modport slave (
        input  sbits_i, aligned_i, unstable_i, mask_i, deadtime_i, cnt_reset_i,
        output sbits_o, active_o, hit_cnt_o, lost_cnt_o, unstable_o
    );

endinterface

// File: rtl/sbit_oneshot_conditioner_oneshot.sv
// Single-channel retrigger one-shot: fires on an eligible hit, then holds off
// for a programmable number of BX. Cleared whenever the link is unaligned.
module sbit_oneshot
    import sbit_oneshot_conditioner_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     sbit,
    input  logic                     mask,
    input  logic                     aligned,
    input  logic [DEADTIME_BITS-1:0] deadtime,
    output logic                     fire,
    output logic                     fire_c
);

    logic [DEADTIME_BITS-1:0] dt_q;
    logic [DEADTIME_BITS-1:0] dt_next;

    // Next fire/holdoff; mask only blocks the fire, a running holdoff keeps counting.
    always_comb begin
        dt_next = dt_q;
        fire_c  = 1'b0;
        if (!aligned) begin
            dt_next = '0;
        end else if (dt_q != '0) begin
            dt_next = dt_q - DEADTIME_BITS'(1);
        end else if (sbit && !mask) begin
            fire_c  = 1'b1;
            dt_next = deadtime;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dt_q <= '0;
            fire <= 1'b0;
        end else begin
            dt_q <= dt_next;
            fire <= fire_c;
        end
    end

endmodule

// File: rtl/sbit_oneshot_conditioner.sv
// Per-VFAT S-bit conditioner: mask, per-channel one-shot and alignment gating,
// plus saturating hit/alignment-loss counters for slow control.
module sbit_oneshot_conditioner
    import sbit_oneshot_conditioner_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    sbit_oneshot_conditioner_if.slave   bus
);

    logic [MXSBITS-1:0]       sbits_q;
    logic [MXSBITS-1:0]       fire_c;
    logic                     active_q;
    logic [HIT_CNT_BITS-1:0]  hit_cnt_q;
    logic [LOST_CNT_BITS-1:0] lost_cnt_q;
    logic                     aligned_d_q;
    logic                     unstable_q;

    for (genvar g = 0; g < MXSBITS; g++) begin : g_ch
        sbit_oneshot u_oneshot (
            .clock    (clock),
            .reset    (reset),
            .sbit     (bus.sbits_i[g]),
            .mask     (bus.mask_i[g]),
            .aligned  (bus.aligned_i),
            .deadtime (bus.deadtime_i),
            .fire     (sbits_q[g]),
            .fire_c   (fire_c[g])
        );
    end

    // active is registered from the next-state fires so it lines up with sbits_o.
    always_ff @(posedge clock) begin
        if (reset) begin
            active_q    <= 1'b0;
            hit_cnt_q   <= '0;
            lost_cnt_q  <= '0;
            aligned_d_q <= 1'b0;
            unstable_q  <= 1'b0;
        end else begin
            active_q    <= |fire_c;
            aligned_d_q <= bus.aligned_i;
            unstable_q  <= bus.unstable_i;
            if (bus.cnt_reset_i) begin
                hit_cnt_q  <= '0;
                lost_cnt_q <= '0;
            end else begin
                if (|fire_c) begin
                    hit_cnt_q <= HIT_CNT_BITS'(sat_inc(32'(hit_cnt_q), HIT_CNT_BITS));
                end
                if (aligned_d_q && !bus.aligned_i) begin
                    lost_cnt_q <= LOST_CNT_BITS'(sat_inc(32'(lost_cnt_q), LOST_CNT_BITS));
                end
            end
        end
    end

    assign bus.sbits_o    = sbits_q;
    assign bus.active_o   = active_q;
    assign bus.hit_cnt_o  = hit_cnt_q;
    assign bus.lost_cnt_o = lost_cnt_q;
    assign bus.unstable_o = unstable_q;

endmodule

// File: tb/tb_sbit_oneshot_conditioner.sv
// Self-checking bench: directed scenarios plus random traffic, checked against
// a cycle-indexed holdoff model of the conditioner.
module tb_sbit_oneshot_conditioner;
    import sbit_oneshot_conditioner_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    sbit_oneshot_conditioner_if bus();

    sbit_oneshot_conditioner dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference: each channel is blocked up to (and including) cycle blk[ch].
    longint             t;
    longint             blk [MXSBITS];
    logic               m_aprev;
    logic [63:0]        m_sbits;
    logic               m_active;
    logic [15:0]        m_hit;
    logic [7:0]         m_lost;
    logic               m_unst;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic model_update();
        logic [63:0] f;
        f = '0;
        if (reset) begin
            for (int c = 0; c < MXSBITS; c++) blk[c] = -1;
            m_aprev = 1'b0; m_hit = '0; m_lost = '0; m_unst = 1'b0;
        end else begin
            for (int c = 0; c < MXSBITS; c++) begin
                if (!bus.aligned_i) begin
                    blk[c] = -1;
                end else if (bus.sbits_i[c] && !bus.mask_i[c] && t > blk[c]) begin
                    f[c]   = 1'b1;
                    blk[c] = t + longint'(bus.deadtime_i);
                end
            end
            if (bus.cnt_reset_i) begin
                m_hit = '0; m_lost = '0;
            end else begin
                if (f != 0 && m_hit != 16'hFFFF) m_hit = m_hit + 16'd1;
                if (m_aprev && !bus.aligned_i && m_lost != 8'hFF) m_lost = m_lost + 8'd1;
            end
            m_aprev = bus.aligned_i;
            m_unst  = bus.unstable_i;
        end
        m_sbits  = f;
        m_active = (f != 0);
    endtask

    task automatic step();
        model_update();
        @(posedge clock);
        #1;
        t++;
        chk("sbits_o",    bus.sbits_o,             m_sbits);
        chk("active_o",   64'(bus.active_o),       64'(m_active));
        chk("hit_cnt_o",  64'(bus.hit_cnt_o),      64'(m_hit));
        chk("lost_cnt_o", 64'(bus.lost_cnt_o),     64'(m_lost));
        chk("unstable_o", 64'(bus.unstable_o),     64'(m_unst));
    endtask

    task automatic clr_counters();
        bus.cnt_reset_i = 1'b1;
        step();
        bus.cnt_reset_i = 1'b0;
    endtask

    logic [11:0] pat;

    initial begin
        t = 0;
        for (int c = 0; c < MXSBITS; c++) blk[c] = -1;
        m_aprev = 0; m_hit = 0; m_lost = 0; m_unst = 0; m_sbits = 0; m_active = 0;
        bus.sbits_i = '0; bus.aligned_i = 1'b0; bus.unstable_i = 1'b0;
        bus.mask_i = '0; bus.deadtime_i = '0; bus.cnt_reset_i = 1'b0;
        reset = 1'b1;
        step(); step();
        chk("rst_sbits", bus.sbits_o, 64'h0);
        chk("rst_hit", 64'(bus.hit_cnt_o), 64'h0);

        // Registered passthrough with deadtime 0
        reset = 1'b0;
        bus.aligned_i = 1'b1;
        bus.sbits_i = 64'h8000_0000_0000_0001;
        step();
        chk("pass_sbits", bus.sbits_o, 64'h8000_0000_0000_0001);
        chk("pass_active", 64'(bus.active_o), 64'h1);
        chk("pass_hit", 64'(bus.hit_cnt_o), 64'h1);
        bus.sbits_i = '0;
        step();

        // One-shot with deadtime 3 on a held input
        clr_counters();
        bus.deadtime_i = 4'd3;
        bus.sbits_i = 64'h1 << 5;
        for (int k = 0; k < 12; k++) begin
            step();
            pat[k] = bus.sbits_o[5];
        end
        chk("oneshot_pattern", 64'(pat), 64'h111);
        chk("oneshot_hit", 64'(bus.hit_cnt_o), 64'h3);
        bus.sbits_i = '0;
        repeat (4) step();

        // Mask blocks the fire
        bus.mask_i = 64'h1 << 7;
        bus.sbits_i = 64'h1 << 7;
        repeat (3) step();
        chk("mask_blocks", 64'(bus.sbits_o[7]), 64'h0);
        bus.mask_i = '0;
        bus.deadtime_i = 4'd15;
        clr_counters();
        chk("mask_fire", 64'(bus.sbits_o[7]), 64'h1);
        repeat (3) step();
        chk("holdoff", 64'(bus.sbits_o[7]), 64'h0);
        bus.aligned_i = 1'b0;
        step();
        chk("unaligned_zero", 64'(bus.sbits_o[7]), 64'h0);
        bus.aligned_i = 1'b1;
        step();
        chk("realign_refire", 64'(bus.sbits_o[7]), 64'h1);
        chk("lost_one", 64'(bus.lost_cnt_o), 64'h1);
        bus.sbits_i = '0;
        repeat (17) step();

        // Hit counter saturation, then clear wins over increment
        bus.deadtime_i = 4'd0;
        bus.sbits_i = 64'h1;
        repeat (70000) step();
        chk("hit_sat", 64'(bus.hit_cnt_o), 64'hFFFF);
        clr_counters();
        chk("hit_clear_prio", 64'(bus.hit_cnt_o), 64'h0);
        bus.sbits_i = '0;
        step();

        // Reset in the middle of a holdoff
        bus.deadtime_i = 4'd10;
        bus.sbits_i = 64'h1;
        step(); step(); step();
        reset = 1'b1;
        step();
        chk("midrst_sbits", bus.sbits_o, 64'h0);
        chk("midrst_active", 64'(bus.active_o), 64'h0);
        chk("midrst_hit", 64'(bus.hit_cnt_o), 64'h0);
        reset = 1'b0;
        step();
        chk("postrst_fire", 64'(bus.sbits_o[0]), 64'h1);
        bus.sbits_i = '0;

        // Low alignment out of reset does not count; then saturate loss counter
        reset = 1'b1;
        bus.aligned_i = 1'b0;
        step();
        reset = 1'b0;
        repeat (5) step();
        chk("lost_from_reset", 64'(bus.lost_cnt_o), 64'h0);
        for (int k = 0; k < 300; k++) begin
            bus.aligned_i = 1'b1; step();
            bus.aligned_i = 1'b0; step();
        end
        chk("lost_sat", 64'(bus.lost_cnt_o), 64'hFF);

        // Random traffic
        bus.aligned_i = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            bus.sbits_i    = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            bus.aligned_i  = ($urandom_range(0, 19) != 0);
            bus.unstable_i = 1'($urandom);
            bus.cnt_reset_i = ($urandom_range(0, 49) == 0);
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 31) == 0) bus.mask_i = {$urandom, $urandom} & {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) bus.deadtime_i = 4'($urandom);
            step();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
